// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// tick_scheduler -- pixel/ms/physics/scroll strobes with IDLE/RUN/PAUSE/STEP control (option: TICK_SCHED_SPEEDUP_EN)
// Revision 1.0
// ============================================================================
module tick_scheduler #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int PHYS_MS       = 10,
    parameter int SCROLL_MS     = 20,
    parameter int MIN_SCROLL_MS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_start,
    input  logic       cmd_pause,
    input  logic       cmd_step,
    input  logic       cmd_stop,
    output logic       pix_en,
    output logic       ms_tick,
    output logic       phys_tick,
    output logic       scroll_tick,
    output logic [1:0] state,
    output logic [7:0] scroll_period
);

    localparam int                DIV         = CLK_HZ / 1000;
    localparam int                PRE_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(DIV - 1);
    localparam logic [7:0]        PHYS_LAST   = 8'(PHYS_MS - 1);
    localparam logic [7:0]        SCROLL_INIT = 8'(SCROLL_MS);

    if ((CLK_HZ % 1000) != 0 || CLK_HZ < 1000 || PHYS_MS < 1 || PHYS_MS > 255 ||
        SCROLL_MS < 1 || SCROLL_MS > 255 || MIN_SCROLL_MS < 1 ||
        MIN_SCROLL_MS > SCROLL_MS) begin : g_bad_params
        $error("tick_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       pix_cnt;
    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       phys_cnt;
    logic [7:0]       scroll_cnt;
    logic [7:0]       period_q;
    logic             phys_tick_q;
    logic             scroll_tick_q;
    logic             start_run;
    logic             phys_adv;
    logic             scroll_adv;
    logic             phys_wrap;
    logic             scroll_wrap;

    assign pix_en        = (pix_cnt == 2'd3);
    assign ms_tick       = (pre_cnt == PRE_LAST);
    assign phys_tick     = phys_tick_q;
    assign scroll_tick   = scroll_tick_q;
    assign state         = state_q;
    assign scroll_period = period_q;

    assign start_run   = (state_q == IDLE) && (state_d == RUN);
    assign phys_adv    = ms_tick && ((state_q == RUN) || (state_q == STEP));
    assign scroll_adv  = ms_tick && (state_q == RUN);
    assign phys_wrap   = (phys_cnt >= PHYS_LAST);
    // >= keeps the wrap safe if the period shrinks below a held count
    assign scroll_wrap = (scroll_cnt >= (period_q - 8'd1));

    always_comb begin
        state_d = state_q;
        if (cmd_stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cmd_start) state_d = RUN;
                RUN:     if (cmd_pause) state_d = PAUSE;
                PAUSE: begin
                    if (cmd_start)     state_d = RUN;
                    else if (cmd_step) state_d = STEP;
                end
                STEP:    if (phys_tick_q) state_d = PAUSE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pix_cnt       <= '0;
            pre_cnt       <= '0;
            phys_cnt      <= '0;
            scroll_cnt    <= '0;
            phys_tick_q   <= 1'b0;
            scroll_tick_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_cnt <= pix_cnt + 2'd1;
            pre_cnt <= ms_tick ? '0 : pre_cnt + 1'b1;
            if (start_run) begin
                phys_cnt   <= '0;
                scroll_cnt <= '0;
            end else begin
                if (phys_adv)   phys_cnt   <= phys_wrap   ? 8'd0 : phys_cnt + 8'd1;
                if (scroll_adv) scroll_cnt <= scroll_wrap ? 8'd0 : scroll_cnt + 8'd1;
            end
            // ticks earned on the stop edge are dropped so IDLE stays quiet
            phys_tick_q   <= phys_adv && phys_wrap && !cmd_stop;
            scroll_tick_q <= scroll_adv && scroll_wrap && !cmd_stop;
        end
    end

`ifdef TICK_SCHED_SPEEDUP_EN
    localparam logic [7:0] MIN_PERIOD = 8'(MIN_SCROLL_MS);
    logic [3:0] speed_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            speed_cnt <= '0;
            period_q  <= SCROLL_INIT;
        end else if (start_run) begin
            speed_cnt <= '0;
            period_q  <= SCROLL_INIT;
        end else if (scroll_tick_q) begin
            speed_cnt <= speed_cnt + 4'd1;
            if (speed_cnt == 4'hF && period_q > MIN_PERIOD)
                period_q <= period_q - 8'd1;
        end
    end
`else
    assign period_q = SCROLL_INIT;
`endif

endmodule
`default_nettype wire
